bnn_window_pe: RTL and testbench

BNN_WINDOW_PE -- requirements
Module: bnn_window_pe

---
 rtl/bnn_window_pe.sv | 221 ++++++++++++++++++++++
 tb/tb_bnn_window_pe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_window_pe.sv
// ---------------------------------------------------------------------------
// bnn_window_pe
//
// Binary neural network processing element for one 3x3 window of 32-channel
// binary pixels. A nine-slot window store is filled through one-hot load
// strobes. A compute request snapshots the window, the weights and the control
// inputs. It then counts XNOR matches across all nine slots and folds the count
// into a saturating 16-bit accumulator. On the last channel group it emits a
// thresholded binary activation through a valid/ready handshake.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous reset, active-high
//   load_en[8:0]   one-hot window slot write strobe (row-major 3x3)
//   pixel_in[31:0] ifmap word, one bit per channel, 1 means +1
//   pad_in         the slot write stores zero instead of pixel_in
//   channel_en     per-channel valid mask, sampled with PE_start
//   weight_in      slot i weights at bits [32i+31:32i], sampled with PE_start
//   threshold      unsigned activation threshold, sampled with PE_start
//   PE_start       compute request (window complete)
//   first_channel  clears the accumulator before the add
//   last_channel   produces an activation after the add
//   act_out        binary activation
//   act_valid      act_out valid
//   act_ready      consumer accepts act_out
//   busy           request in flight, PE_start is not accepted
//   pe_overrun     sticky flag: PE_start was dropped while busy
//
// Configuration
//   BNN_PE_PIPE_EN  When defined, the popcount is split into two registered
//                   stages (slots 0-4, then slots 5-8 plus the sum). This adds
//                   one cycle of latency and nothing else changes.
// ---------------------------------------------------------------------------
module bnn_window_pe (
  input  logic         clk,
  input  logic         rst,
  input  logic [8:0]   load_en,
  input  logic [31:0]  pixel_in,
  input  logic         pad_in,
  input  logic [31:0]  channel_en,
  input  logic [287:0] weight_in,
  input  logic [15:0]  threshold,
  input  logic         PE_start,
  input  logic         first_channel,
  input  logic         last_channel,
  output logic         act_out,
  output logic         act_valid,
  input  logic         act_ready,
  output logic         busy,
  output logic         pe_overrun
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] POP  = 3'd1;
  localparam logic [2:0] ACC  = 3'd2;
  localparam logic [2:0] OUT  = 3'd3;
`ifdef BNN_PE_PIPE_EN
  localparam logic [2:0] POP2 = 3'd4;
`endif

  logic [31:0]  window_q [9];
  logic [31:0]  winSnap_q [9];
  logic [287:0] weightSnap_q;
  logic [31:0]  chenSnap_q;
  logic [15:0]  thrSnap_q;
  logic         firstSnap_q;
  logic         lastSnap_q;

  logic [2:0]   state_q, state_d;
  logic [15:0]  acc_q, acc_d;
  logic         actOut_q, actOut_d;
  logic         actValid_q, actValid_d;
  logic         overrun_q, overrun_d;
  logic [8:0]   match_q;
  logic         snapEn;

  logic [8:0]   sumLo, sumHi;
  logic [31:0]  slotMatch;
  logic [16:0]  accSum;

  function automatic logic [8:0] popCount32(input logic [31:0] v);
    logic [8:0] n;
    n = '0;
    for (int b = 0; b < 32; b++) n = n + {8'b0, v[b]};
    return n;
  endfunction

  // Window store. Slots can be written in any state. The in-flight compute
  // reads only the snapshot, so a write here cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) window_q[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++)
        if (load_en[i]) window_q[i] <= pad_in ? 32'h0 : pixel_in;
    end
  end

  // Operand snapshot, taken only on an accepted PE_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) winSnap_q[i] <= '0;
      weightSnap_q <= '0;
      chenSnap_q   <= '0;
      thrSnap_q    <= '0;
      firstSnap_q  <= 1'b0;
      lastSnap_q   <= 1'b0;
    end else if (snapEn) begin
      for (int i = 0; i < 9; i++) winSnap_q[i] <= window_q[i];
      weightSnap_q <= weight_in;
      chenSnap_q   <= channel_en;
      thrSnap_q    <= threshold;
      firstSnap_q  <= first_channel;
      lastSnap_q   <= last_channel;
    end
  end

  // XNOR match counts, split into slots 0-4 and slots 5-8 so that the
  // pipelined build can register the two halves separately.
  always_comb begin
    sumLo     = '0;
    sumHi     = '0;
    slotMatch = '0;
    for (int s = 0; s < 9; s++) begin
      slotMatch = ~(winSnap_q[s] ^ weightSnap_q[32*s +: 32]) & chenSnap_q;
      if (s < 5) sumLo = sumLo + popCount32(slotMatch);
      else       sumHi = sumHi + popCount32(slotMatch);
    end
  end

`ifdef BNN_PE_PIPE_EN
  logic [8:0] partial_q;

  // Two-stage popcount: POP registers the slot 0-4 half, and POP2 adds the
  // slot 5-8 half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      partial_q <= '0;
      match_q   <= '0;
    end else begin
      if (state_q == POP)  partial_q <= sumLo;
      if (state_q == POP2) match_q   <= partial_q + sumHi;
    end
  end
`else
  // Single-stage popcount registered in POP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= '0;
    end else if (state_q == POP) begin
      match_q <= sumLo + sumHi;
    end
  end
`endif

  // Next-state logic. The activation is computed from acc_d in ACC, so that
  // act_out is registered on the same edge that raises act_valid.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    actOut_d   = actOut_q;
    actValid_d = actValid_q;
    overrun_d  = overrun_q | (PE_start && (state_q != IDLE));
    snapEn     = 1'b0;
    accSum     = {1'b0, firstSnap_q ? 16'h0 : acc_q} + {8'b0, match_q};
    case (state_q)
      IDLE: begin
        if (PE_start) begin
          snapEn  = 1'b1;
          state_d = POP;
        end
      end
`ifdef BNN_PE_PIPE_EN
      POP:  state_d = POP2;
      POP2: state_d = ACC;
`else
      POP:  state_d = ACC;
`endif
      ACC: begin
        acc_d = accSum[16] ? 16'hFFFF : accSum[15:0];
        if (lastSnap_q) begin
          actOut_d   = (acc_d >= thrSnap_q);
          actValid_d = 1'b1;
          state_d    = OUT;
        end else begin
          state_d = IDLE;
        end
      end
      OUT: begin
        if (act_ready) begin
          actValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      actOut_q   <= 1'b0;
      actValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      actOut_q   <= actOut_d;
      actValid_q <= actValid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign act_out    = actOut_q;
  assign act_valid  = actValid_q;
  assign busy       = (state_q != IDLE);
  assign pe_overrun = overrun_q;

endmodule

// File: tb/tb_bnn_window_pe.sv
// ---------------------------------------------------------------------------
// tb_bnn_window_pe
//
// Directed bench for bnn_window_pe. Every expected activation below is worked
// out by hand from the match count, for example 9 slots x 32 channels = 288,
// with the channel mask 16'hFFFF giving 9 x 16 = 144. Inputs are driven and
// outputs sampled 1 ns after the rising edge. Define BNN_PE_PIPE_EN for both
// the bench and the RTL to cover the pipelined build.
// ---------------------------------------------------------------------------
module tb_bnn_window_pe;

`ifdef BNN_PE_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [8:0]   load_en;
  logic [31:0]  pixel_in;
  logic         pad_in;
  logic [31:0]  channel_en;
  logic [287:0] weight_in;
  logic [15:0]  threshold;
  logic         PE_start;
  logic         first_channel;
  logic         last_channel;
  logic         act_out;
  logic         act_valid;
  logic         act_ready;
  logic         busy;
  logic         pe_overrun;

  int checkCount = 0;
  int errorCount = 0;

  logic [287:0] allOnes;
  logic [287:0] w100;

  bnn_window_pe dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .pixel_in      (pixel_in),
    .pad_in        (pad_in),
    .channel_en    (channel_en),
    .weight_in     (weight_in),
    .threshold     (threshold),
    .PE_start      (PE_start),
    .first_channel (first_channel),
    .last_channel  (last_channel),
    .act_out       (act_out),
    .act_valid     (act_valid),
    .act_ready     (act_ready),
    .busy          (busy),
    .pe_overrun    (pe_overrun)
  );

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  // Single comparison point: count it, and report it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write every window slot in one cycle.
  task automatic loadWindow(input logic [31:0] pix, input logic pad);
    load_en  = 9'h1FF;
    pixel_in = pix;
    pad_in   = pad;
    tick();
    load_en  = '0;
    pad_in   = 1'b0;
  endtask

  // Present a compute request for one edge (edge T).
  task automatic applyStimulus(input logic [287:0] w, input logic [31:0] chen,
                               input logic [15:0] thr, input logic first,
                               input logic last);
    weight_in     = w;
    channel_en    = chen;
    threshold     = thr;
    first_channel = first;
    last_channel  = last;
    PE_start      = 1'b1;
    tick();
    PE_start      = 1'b0;
  endtask

  // Called `elapsed` cycles after edge T. act_valid must still be low one
  // cycle before T+LAT and high at T+LAT, carrying the expected activation.
  task automatic expectResult(input string tag, input logic expAct, input int elapsed);
    for (int k = elapsed + 1; k < LAT; k++) tick();
    checkOutput({tag, "_early"}, {31'b0, act_valid}, 32'd0);
    tick();
    checkOutput({tag, "_valid"}, {31'b0, act_valid}, 32'd1);
    checkOutput({tag, "_act"}, {31'b0, act_out}, {31'b0, expAct});
  endtask

  // Accept the pending result. The PE must be idle afterwards.
  task automatic consume(input string tag);
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
    checkOutput({tag, "_drop_valid"}, {31'b0, act_valid}, 32'd0);
    checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  // A group with last_channel=0 returns to IDLE with no result.
  task automatic runGroup(input string tag, input logic [287:0] w, input logic [15:0] thr,
                          input logic first, input logic doCheck);
    applyStimulus(w, 32'hFFFF_FFFF, thr, first, 1'b0);
    repeat (LAT) tick();
    if (doCheck) begin
      checkOutput({tag, "_noresult"}, {31'b0, act_valid}, 32'd0);
      checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    allOnes = '1;
    w100    = '0;
    for (int i = 0; i < 100; i++) w100[i] = 1'b1;

    rst = 1'b1; load_en = '0; pixel_in = '0; pad_in = 1'b0; channel_en = '0;
    weight_in = '0; threshold = '0; PE_start = 1'b0; first_channel = 1'b0;
    last_channel = 1'b0; act_ready = 1'b0;

    // Reset state
    tick(); tick();
    checkOutput("rst_act_valid", {31'b0, act_valid}, 32'd0);
    checkOutput("rst_act_out", {31'b0, act_out}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_overrun", {31'b0, pe_overrun}, 32'd0);
    rst = 1'b0;

    // Start on the edge right after reset. The window is all zero and the
    // weights are zero, so every channel matches: 288 >= 288.
    applyStimulus('0, 32'hFFFF_FFFF, 16'd288, 1'b1, 1'b1);
    checkOutput("start_busy", {31'b0, busy}, 32'd1);
    expectResult("after_rst", 1'b1, 0);
    consume("after_rst");

    // All-ones window and weights, threshold 288. The window is overwritten
    // with pad zeros during the flight and must not affect the result.
    loadWindow(32'hFFFF_FFFF, 1'b0);
    applyStimulus(allOnes, 32'hFFFF_FFFF, 16'd288, 1'b1, 1'b1);
    loadWindow(32'hFFFF_FFFF, 1'b1);
    expectResult("full288", 1'b1, 1);
    consume("full288");
    loadWindow(32'hFFFF_FFFF, 1'b0);

    // Threshold just above the count, then the half channel mask (144).
    applyStimulus(allOnes, 32'hFFFF_FFFF, 16'd289, 1'b1, 1'b1);
    expectResult("thr289", 1'b0, 0);
    consume("thr289");
    applyStimulus(allOnes, 32'h0000_FFFF, 16'd144, 1'b1, 1'b1);
    expectResult("half144", 1'b1, 0);
    consume("half144");
    applyStimulus(allOnes, 32'h0000_FFFF, 16'd145, 1'b1, 1'b1);
    expectResult("half145", 1'b0, 0);
    consume("half145");

    // Three groups of 100 matches each, for an accumulated count of 300.
    runGroup("g1", w100, 16'd300, 1'b1, 1'b1);
    runGroup("g2", w100, 16'd300, 1'b0, 1'b1);
    applyStimulus(w100, 32'hFFFF_FFFF, 16'd300, 1'b0, 1'b1);
    expectResult("acc300", 1'b1, 0);
    consume("acc300");
    runGroup("h1", w100, 16'd301, 1'b1, 1'b0);
    runGroup("h2", w100, 16'd301, 1'b0, 1'b0);
    applyStimulus(w100, 32'hFFFF_FFFF, 16'd301, 1'b0, 1'b1);
    expectResult("acc301", 1'b0, 0);
    consume("acc301");

    // Saturation: 231 x 288 = 66528 exceeds 16 bits. A wrapping
    // accumulator would hold 992 and fail the 16'hFFFF threshold.
    for (int g = 0; g < 230; g++) runGroup("sat", allOnes, 16'hFFFF, (g == 0), 1'b0);
    applyStimulus(allOnes, 32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b1);
    expectResult("saturate", 1'b1, 0);
    consume("saturate");

    // Backpressure: hold act_ready low for 5 cycles. A PE_start in that
    // window is dropped, sets the overrun flag and produces no second result.
    applyStimulus(allOnes, 32'hFFFF_FFFF, 16'd288, 1'b1, 1'b1);
    repeat (LAT) tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        threshold = 16'hFFFF;
        PE_start  = 1'b1;
      end
      tick();
      PE_start = 1'b0;
      checkOutput("hold_valid", {31'b0, act_valid}, 32'd1);
      checkOutput("hold_act", {31'b0, act_out}, 32'd1);
    end
    checkOutput("overrun_set", {31'b0, pe_overrun}, 32'd1);
    consume("hold");
    repeat (LAT + 2) tick();
    checkOutput("no_second_result", {31'b0, act_valid}, 32'd0);
    checkOutput("overrun_sticky", {31'b0, pe_overrun}, 32'd1);

    // Pad writes give an all-zero window, which matches zero weights.
    loadWindow(32'hFFFF_FFFF, 1'b1);
    applyStimulus('0, 32'hFFFF_FFFF, 16'd288, 1'b1, 1'b1);
    expectResult("pad", 1'b1, 0);
    consume("pad");

    // Reset in flight at T+1, with an all-ones window loaded beforehand.
    loadWindow(32'hFFFF_FFFF, 1'b0);
    applyStimulus(allOnes, 32'hFFFF_FFFF, 16'd288, 1'b1, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
    checkOutput("midrst_valid", {31'b0, act_valid}, 32'd0);
    checkOutput("midrst_act", {31'b0, act_out}, 32'd0);
    checkOutput("midrst_overrun", {31'b0, pe_overrun}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (LAT + 1) tick();
    checkOutput("midrst_no_result", {31'b0, act_valid}, 32'd0);
    // The accumulator must be zero: 0 + 9 (one channel x 9 slots) < 10.
    applyStimulus('0, 32'h0000_0001, 16'd10, 1'b0, 1'b1);
    expectResult("midrst_acc0", 1'b0, 0);
    consume("midrst_acc0");
    // The window must be zero: it matches zero weights on all 288 channels.
    applyStimulus('0, 32'hFFFF_FFFF, 16'd288, 1'b1, 1'b1);
    expectResult("midrst_win0", 1'b1, 0);
    consume("midrst_win0");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
